// File: rtl/lab2_truth_table_sweeper.sv
// lab2_truth_table_sweeper: drives {w,x} through 00,01,10,11, captures y_in per vector, grades against EXPECTED.
// Ports: clk/rst_n (async active-low), start (sampled in IDLE), y_in (returned y),
// w/x (stimulus), busy, done (1-cycle pulse), table_out[3:0], pass,
// err_count[7:0] only when LAB2_SWEEP_ERRCNT_EN is defined (saturating failed-sweep count).
module lab2_truth_table_sweeper #(
  parameter int         DWELL    = 4,
  parameter logic [3:0] EXPECTED = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       w,
  output logic       x,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic       pass
`ifdef LAB2_SWEEP_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);
  localparam int CW = $clog2(DWELL + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;
  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_q, w_d, x_q, x_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]    table_q, table_d;
  logic          last;
  assign last = cnt_q == CW'(DWELL - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = DRIVE;
        table_d = '0;
        pass_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      DRIVE: if (last) begin
        // y_in is only trusted on the final dwell cycle of each vector
        table_d[idx_q] = y_in;
        cnt_d          = '0;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = table_d == EXPECTED;
        end else idx_d = idx_q + 2'd1;
      end else cnt_d = cnt_q + CW'(1);
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // stimulus registered from next state so w,x are zero outside DRIVE
    w_d = (state_d == DRIVE) & idx_d[1];
    x_d = (state_d == DRIVE) & idx_d[0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      pass_q  <= pass_d;
    end
  end
  assign w         = w_q;
  assign x         = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign pass      = pass_q;
`ifdef LAB2_SWEEP_ERRCNT_EN
  logic [7:0] err_q, err_d;
  // counts on entry to DONE so the new value is visible during the done pulse
  always_comb err_d = (state_q == DRIVE && state_d == DONE && table_d != EXPECTED && err_q != 8'hff) ? err_q + 8'd1 : err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else err_q <= err_d;
  end
  assign err_count = err_q;
`endif
endmodule

// File: tb/tb_lab2_truth_table_sweeper.sv
// tb_lab2_truth_table_sweeper: random-table sweeps on DWELL=4 and DWELL=1 instances against a cycle-count model.
module tb_lab2_truth_table_sweeper;
  localparam int D4 = 4;
  localparam int D1 = 1;
  logic clk = 1'b0, rst_n = 1'b0, start4 = 1'b0, start1 = 1'b0, gl4 = 1'b0;
  logic [3:0] lut4 = '0, lut1 = '0;
  logic w4, x4, busy4, done4, pass4, y4;
  logic w1, x1, busy1, done1, pass1, y1;
  logic [3:0] tab4, tab1;
  int n_chk = 0, n_err = 0, err4 = 0, err1 = 0;
`ifdef LAB2_SWEEP_ERRCNT_EN
  logic [7:0] ec4, ec1;
`endif
  assign y4 = lut4[{w4, x4}] ^ gl4;
  assign y1 = lut1[{w1, x1}];
  always #5 clk = ~clk;
  lab2_truth_table_sweeper #(.DWELL(D4), .EXPECTED(4'b1110)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .y_in(y4), .w(w4), .x(x4),
    .busy(busy4), .done(done4), .table_out(tab4), .pass(pass4)
`ifdef LAB2_SWEEP_ERRCNT_EN
    , .err_count(ec4)
`endif
  );
  lab2_truth_table_sweeper #(.DWELL(D1), .EXPECTED(4'b1110)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1), .w(w1), .x(x1),
    .busy(busy1), .done(done1), .table_out(tab1), .pass(pass1)
`ifdef LAB2_SWEEP_ERRCNT_EN
    , .err_count(ec1)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // one sweep on the DWELL=4 instance; cycle c counts from 1 after the accepting edge
  task automatic sweep4(input logic [3:0] lut, input bit ign, input bit gl);
    @(negedge clk);
    lut4 = lut;
    start4 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4 * D4 + 1; c++) begin
      @(negedge clk);
      start4 = ign && (c == 3 || c == 9);
      gl4 = gl && c <= 4 * D4 && (c % D4 != 0) && ($urandom % 2 == 1);
      if (c <= 4 * D4) begin
        check("busy4", busy4, 1);
        check("done4_early", done4, 0);
        check("wx4", {w4, x4}, (c - 1) / D4);
      end else begin
        check("busy4_in_done", busy4, 0);
        check("done4", done4, 1);
        check("wx4_in_done", {w4, x4}, 0);
        check("table4", tab4, lut);
        check("pass4", pass4, lut == 4'b1110);
      end
    end
    gl4 = 1'b0;
    if (lut != 4'b1110 && err4 < 255) err4++;
    @(negedge clk);
    check("busy4_idle", busy4, 0);
    check("done4_idle", done4, 0);
    check("table4_hold", tab4, lut);
    check("pass4_hold", pass4, lut == 4'b1110);
`ifdef LAB2_SWEEP_ERRCNT_EN
    check("err4", ec4, err4);
`endif
  endtask
  task automatic sweep1(input logic [3:0] lut);
    @(negedge clk);
    lut1 = lut;
    start1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      check("busy1", busy1, c <= 4);
      check("done1", done1, c == 5);
      if (c <= 4) check("wx1", {w1, x1}, c - 1);
    end
    check("table1", tab1, lut);
    check("pass1", pass1, lut == 4'b1110);
    if (lut != 4'b1110 && err1 < 255) err1++;
    @(negedge clk);
    check("done1_idle", done1, 0);
`ifdef LAB2_SWEEP_ERRCNT_EN
    check("err1", ec1, err1);
`endif
  endtask
  initial begin
    logic [3:0] r;
    repeat (2) @(negedge clk);
    check("rst_busy", {busy4, busy1}, 0);
    check("rst_done", {done4, done1}, 0);
    check("rst_wx", {w4, x4, w1, x1}, 0);
    check("rst_table", {tab4, tab1}, 0);
    check("rst_pass", {pass4, pass1}, 0);
`ifdef LAB2_SWEEP_ERRCNT_EN
    check("rst_err", {ec4, ec1}, 0);
`endif
    rst_n = 1'b1;
    sweep4(4'b1110, 1'b0, 1'b0);
    sweep4(4'b0000, 1'b0, 1'b1);
    sweep4(4'b1110, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) sweep4(4'($urandom), $urandom % 2 == 1, 1'b1);
    // start held high: back-to-back sweeps one IDLE cycle apart
    @(negedge clk);
    lut4 = 4'b1110;
    start4 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start4 = c < 35;
      check("held_busy", busy4, (c >= 1 && c <= 16) || (c >= 19 && c <= 34));
      check("held_done", done4, c == 17 || c == 35);
      if (c == 17 || c == 35) check("held_pass", pass4, 1);
    end
    // reset in cycle 7 of a sweep whose first table bit is already captured
    @(negedge clk);
    lut4 = 4'b1111;
    start4 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (c == 7) begin
        rst_n = 1'b0;
        err4 = 0;
        #1;
        check("mid_rst_outs", {busy4, done4, w4, x4, pass4}, 0);
        check("mid_rst_table", tab4, 0);
`ifdef LAB2_SWEEP_ERRCNT_EN
        check("mid_rst_err", ec4, 0);
`endif
      end
      if (c == 9) rst_n = 1'b1;
      if (c >= 7) begin
        check("post_rst_done", done4, 0);
        check("post_rst_busy", busy4, 0);
        check("post_rst_table", tab4, 0);
      end
    end
    sweep4(4'b1110, 1'b0, 1'b1);
    sweep1(4'b0110);
    for (int i = 0; i < 299; i++) begin
      r = 4'($urandom);
      sweep1(r == 4'b1110 ? 4'b0110 : r);
    end
`ifdef LAB2_SWEEP_ERRCNT_EN
    check("err1_saturated", ec1, 255);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
